// File: rtl/seg_scan_pkg.sv
// Shared constants and helpers for the multiplexed seven-segment scan controller.
// No state; pure definitions.
// No flow control.
package seg_scan_pkg;

    localparam int DIGIT_W      = 4;
    localparam int MAX_DIGITS   = 8;
    localparam int SCAN_DIV_DEF = 50000;
    localparam int GUARD_DEF    = 16;

    function automatic logic [MAX_DIGITS-1:0] onehot(input logic [2:0] idx);
        logic [MAX_DIGITS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Keypad-side inputs and display-side outputs of the scan controller.
// Wires only; no latency.
// No backpressure: key_valid is a single-cycle strobe that is always accepted.
interface seg_scan_ctrl_if
    import seg_scan_pkg::*;
#(
    parameter int NUM_DIGITS = 4
);
    localparam int CNT_W = $clog2(NUM_DIGITS + 1);

    logic                          key_valid;
    logic [DIGIT_W-1:0]            key_code;
    logic                          clr;
    logic                          blank_lz;
    logic [DIGIT_W-1:0]            dec_code;
    logic [NUM_DIGITS-1:0]         dig_sel;
    logic [CNT_W-1:0]              entry_cnt;
    logic [DIGIT_W*NUM_DIGITS-1:0] digits;

    modport master (
        output key_valid, key_code, clr, blank_lz,
        input  dec_code, dig_sel, entry_cnt, digits
    );

    modport slave (
        input  key_valid, key_code, clr, blank_lz,
        output dec_code, dig_sel, entry_cnt, digits
    );

endinterface

// File: rtl/seg_digit_buf.sv
// Keypad entry buffer: each key shifts into digit 0, oldest digit falls off the top.
// Latency: digits/entry_cnt update on the edge that samples the strobe.
// No backpressure; clr wins over a simultaneous key, which is dropped.
module seg_digit_buf
    import seg_scan_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int CNT_W      = $clog2(NUM_DIGITS + 1)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          key_valid,
    input  logic [DIGIT_W-1:0]            key_code,
    input  logic                          clr,
    output logic [DIGIT_W*NUM_DIGITS-1:0] digits,
    output logic [CNT_W-1:0]              entry_cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits    <= '0;
            entry_cnt <= '0;
        end else if (clr) begin
            digits    <= '0;
            entry_cnt <= '0;
        end else if (key_valid) begin
            digits <= {digits[DIGIT_W*(NUM_DIGITS-1)-1:0], key_code};
            if (entry_cnt != CNT_W'(NUM_DIGITS))
                entry_cnt <= entry_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Scans the entry buffer across NUM_DIGITS digits through one shared hex decoder.
// Latency: dig_sel/dec_code registered, one cycle behind the scan position.
// No backpressure; the scan free-runs and keys are always accepted.
module seg_scan_ctrl
    import seg_scan_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = SCAN_DIV_DEF,
    parameter int GUARD      = GUARD_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    seg_scan_ctrl_if.slave     bus
);

    localparam int CNT_W = $clog2(NUM_DIGITS + 1);
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int SC_W  = $clog2(SCAN_DIV);

    logic [DIGIT_W*NUM_DIGITS-1:0] digits;
    logic [CNT_W-1:0]              entry_cnt;
    logic [SC_W-1:0]               scan_cnt;
    logic [IDX_W-1:0]              idx;
    logic [MAX_DIGITS-1:0]         sel_full;
    logic                          vis;
    logic [NUM_DIGITS-1:0]         dig_sel_nxt;
    logic [DIGIT_W-1:0]            dec_code_nxt;
    logic [NUM_DIGITS-1:0]         dig_sel_q;
    logic [DIGIT_W-1:0]            dec_code_q;

    seg_digit_buf #(
        .NUM_DIGITS (NUM_DIGITS),
        .CNT_W      (CNT_W)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_valid (bus.key_valid),
        .key_code  (bus.key_code),
        .clr       (bus.clr),
        .digits    (digits),
        .entry_cnt (entry_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt <= '0;
            idx      <= '0;
        end else if (scan_cnt == SC_W'(SCAN_DIV - 1)) begin
            scan_cnt <= '0;
            idx      <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    // Blanking looks at the live entry_cnt so clr/blank_lz take effect mid-slot.
    always_comb begin
        sel_full     = onehot(3'(idx));
        vis          = !bus.blank_lz || (idx == '0) || (CNT_W'(idx) < entry_cnt);
        dig_sel_nxt  = '0;
        if (scan_cnt >= SC_W'(GUARD) && vis)
            dig_sel_nxt = sel_full[NUM_DIGITS-1:0];
        dec_code_nxt = digits[DIGIT_W*int'(idx) +: DIGIT_W];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dig_sel_q  <= '0;
            dec_code_q <= '0;
        end else begin
            dig_sel_q  <= dig_sel_nxt;
            dec_code_q <= dec_code_nxt;
        end
    end

    assign bus.dig_sel   = dig_sel_q;
    assign bus.dec_code  = dec_code_q;
    assign bus.digits    = digits;
    assign bus.entry_cnt = entry_cnt;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomized and directed stimulus for seg_scan_ctrl, checked against a slot-arithmetic model.
module tb_seg_scan_ctrl;

    localparam int N  = 4;
    localparam int SD = 8;
    localparam int G  = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    seg_scan_ctrl_if #(.NUM_DIGITS(N)) bus ();

    seg_scan_ctrl #(
        .NUM_DIGITS (N),
        .SCAN_DIV   (SD),
        .GUARD      (G)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int m_dig [N];
    int m_cnt;
    int t;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0d)", tag, obs, exp, t);
        end
    endtask

    function automatic logic [31:0] model_digits();
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < N; i++)
            v = v | (32'(m_dig[i] & 15) << (4 * i));
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_dig[i] = 0;
        m_cnt = 0;
        t     = 0;
    endtask

    // Called at a negedge: drive one cycle of inputs, predict, then check after the edge.
    task automatic tick(input logic kv, input logic [3:0] kc, input logic cl, input logic blz);
        int          pos;
        int          ix;
        logic [31:0] e_sel;
        logic [31:0] e_dec;
        bus.key_valid = kv;
        bus.key_code  = kc;
        bus.clr       = cl;
        bus.blank_lz  = blz;
        pos   = t % SD;
        ix    = (t / SD) % N;
        e_sel = (pos < G || !(!blz || ix == 0 || ix < m_cnt)) ? 32'd0 : (32'd1 << ix);
        e_dec = 32'(m_dig[ix]);
        if (cl) begin
            for (int i = 0; i < N; i++) m_dig[i] = 0;
            m_cnt = 0;
        end else if (kv) begin
            for (int i = N - 1; i > 0; i--) m_dig[i] = m_dig[i-1];
            m_dig[0] = int'(kc);
            if (m_cnt < N) m_cnt++;
        end
        t++;
        @(negedge clk);
        check("dig_sel",   32'(bus.dig_sel),   e_sel);
        check("dec_code",  32'(bus.dec_code),  e_dec);
        check("digits",    32'(bus.digits),    model_digits());
        check("entry_cnt", 32'(bus.entry_cnt), 32'(m_cnt));
        bus.key_valid = 1'b0;
        bus.clr       = 1'b0;
    endtask

    task automatic idle(input int n, input logic blz);
        for (int i = 0; i < n; i++) tick(1'b0, 4'h0, 1'b0, blz);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_dig_sel"},   32'(bus.dig_sel),   32'd0);
        check({tag, "_dec_code"},  32'(bus.dec_code),  32'd0);
        check({tag, "_digits"},    32'(bus.digits),    32'd0);
        check({tag, "_entry_cnt"}, 32'(bus.entry_cnt), 32'd0);
    endtask

    initial begin
        int guard_cnt;
        bus.key_valid = 1'b0;
        bus.key_code  = 4'h0;
        bus.clr       = 1'b0;
        bus.blank_lz  = 1'b0;
        model_reset();

        #1;
        check_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle scan, two full rotations: 0,0,1.. per slot, wrapping to digit 0.
        idle(2 * N * SD, 1'b0);

        // Keys 1,2,3 then let the scan reach idx 2.
        tick(1'b1, 4'h1, 1'b0, 1'b0);
        tick(1'b1, 4'h2, 1'b0, 1'b0);
        tick(1'b1, 4'h3, 1'b0, 1'b0);
        check("digits_0123", 32'(bus.digits), 32'h0123);
        check("cnt_3", 32'(bus.entry_cnt), 32'd3);
        idle(N * SD, 1'b0);

        // Clear, then five keys: saturation and discard of the oldest digit.
        tick(1'b0, 4'h0, 1'b1, 1'b0);
        for (int k = 1; k <= 5; k++) tick(1'b1, 4'(k), 1'b0, 1'b0);
        check("digits_2345", 32'(bus.digits), 32'h2345);
        check("cnt_sat", 32'(bus.entry_cnt), 32'd4);

        // Leading-zero blanking with one digit entered.
        tick(1'b0, 4'h0, 1'b1, 1'b1);
        tick(1'b1, 4'h7, 1'b0, 1'b1);
        idle(N * SD + 3, 1'b1);
        // Empty buffer with blanking: digit 0 still lit showing 0.
        tick(1'b0, 4'h0, 1'b1, 1'b1);
        idle(N * SD, 1'b1);

        // clr beats a simultaneous key.
        tick(1'b1, 4'h6, 1'b0, 1'b0);
        tick(1'b1, 4'h9, 1'b1, 1'b0);
        check("clr_prio_digits", 32'(bus.digits), 32'd0);
        check("clr_prio_cnt", 32'(bus.entry_cnt), 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            logic kv, cl, blz;
            kv  = ($urandom_range(0, 3) == 0);
            cl  = ($urandom_range(0, 40) == 0);
            blz = (((i / 50) % 2) == 1) ^ ($urandom_range(0, 60) == 0);
            tick(kv, 4'($urandom_range(0, 15)), cl, blz);
        end

        // Reset mid-slot while idx 2 is lit.
        tick(1'b1, 4'hA, 1'b0, 1'b0);
        guard_cnt = 0;
        while (!(((t / SD) % N) == 2 && (t % SD) == 5) && guard_cnt < 4 * N * SD) begin
            tick(1'b0, 4'h0, 1'b0, 1'b0);
            guard_cnt++;
        end
        check("reach_idx2", 32'(guard_cnt < 4 * N * SD), 32'd1);
        check("idx2_lit", 32'(bus.dig_sel), 32'h4);
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        idle(N * SD + 4, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
